// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage ALU front-end.
// Accepts decoded instruction fields and two operands over a valid/ready
// request channel. It decodes them into an ALU operation code and runs one
// or two ALU passes. The registered result, the branch-taken flag and the
// illegal flag are returned over a valid/ready response channel.
//
// Optional build macro: ALU_ISSUE_SUB_EN
//   defined   - R-type SUB runs as two ADD passes: a + ~b, then + 1
//   undefined - R-type SUB decodes as illegal and PASS2 is never entered
module alu_issue_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_aluop,
  input  logic [2:0]               req_funct3,
  input  logic [6:0]               req_funct7,
  input  logic [DATA_WIDTH-1:0]    req_a,
  input  logic [DATA_WIDTH-1:0]    req_b,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic                     rsp_taken,
  output logic                     rsp_illegal
);

  // ALU operation codes understood by the downstream ALU
  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQUAL = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_IDLE  = OPCODE_LENGTH'(4'b1111);

  // Instruction classes carried on req_aluop
  localparam logic [1:0] CLS_MEM    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_RTYPE  = 2'b10;
  localparam logic [1:0] CLS_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_PASS2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_n;

  // Decoded view of the request currently on the input channel
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_branch;
  logic                     dec_invert;
  logic                     dec_illegal;

  // Request fields latched at accept time
  logic [DATA_WIDTH-1:0]    a_q;
  logic [DATA_WIDTH-1:0]    b_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     branch_q;
  logic                     invert_q;

`ifdef ALU_ISSUE_SUB_EN
  logic dec_sub;
  logic sub_q;
`endif

  // Decode the request fields into ALU op code, branch flags and legality
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so a
    // path that skips an assignment cannot infer a latch.
    dec_op      = OP_IDLE;
    dec_branch  = 1'b0;
    dec_invert  = 1'b0;
    dec_illegal = 1'b0;
`ifdef ALU_ISSUE_SUB_EN
    dec_sub     = 1'b0;
`endif
    case (req_aluop)
      CLS_MEM: dec_op = OP_ADD;
      CLS_BRANCH: begin
        dec_branch = 1'b1;
        case (req_funct3)
          3'b000: dec_op = OP_EQUAL;                         // BEQ
          3'b001: begin dec_op = OP_EQUAL; dec_invert = 1'b1; end // BNE
          3'b100: dec_op = OP_SLT;                           // BLT
          3'b101: begin dec_op = OP_SLT; dec_invert = 1'b1; end   // BGE
          default: dec_illegal = 1'b1;
        endcase
      end
      CLS_RTYPE: begin
        case ({req_funct3, req_funct7})
          {3'b000, 7'b0000000}: dec_op = OP_ADD;
          {3'b111, 7'b0000000}: dec_op = OP_AND;
          {3'b100, 7'b0000000}: dec_op = OP_XOR;
          {3'b010, 7'b0000000}: dec_op = OP_SLT;
`ifdef ALU_ISSUE_SUB_EN
          {3'b000, 7'b0100000}: begin dec_op = OP_ADD; dec_sub = 1'b1; end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      CLS_ITYPE: begin
        case (req_funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b100:  dec_op = OP_XOR;
          3'b010:  dec_op = OP_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op     = OP_IDLE;
      dec_branch = 1'b0;
      dec_invert = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic, channel handshakes and ALU operand steering
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    SrcA      = '0;
    SrcB      = '0;
    Operation = OP_IDLE;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = dec_illegal ? S_RESP : S_EXEC;
      end
      S_EXEC: begin
        SrcA      = a_q;
        Operation = op_q;
`ifdef ALU_ISSUE_SUB_EN
        // First half of SUB: a + ~b; the +1 is added in PASS2
        SrcB      = sub_q ? ~b_q : b_q;
        state_n   = sub_q ? S_PASS2 : S_RESP;
`else
        SrcB      = b_q;
        state_n   = S_RESP;
`endif
      end
      S_PASS2: begin
        // Second half of SUB: add one to the captured partial sum
        SrcA      = rsp_result;
        SrcB      = DATA_WIDTH'(1);
        Operation = OP_ADD;
        state_n   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Latch request fields on accept and capture ALU results per pass
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      branch_q    <= 1'b0;
      invert_q    <= 1'b0;
`ifdef ALU_ISSUE_SUB_EN
      sub_q       <= 1'b0;
`endif
      rsp_result  <= '0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q         <= req_a;
            b_q         <= req_b;
            op_q        <= dec_op;
            branch_q    <= dec_branch;
            invert_q    <= dec_invert;
`ifdef ALU_ISSUE_SUB_EN
            sub_q       <= dec_sub;
`endif
            rsp_illegal <= dec_illegal;
            rsp_result  <= '0;
            rsp_taken   <= 1'b0;
          end
        end
        S_EXEC: begin
          rsp_result <= ALUResult;
          rsp_taken  <= branch_q & (ALUResult[0] ^ invert_q);
        end
        S_PASS2: rsp_result <= ALUResult;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven bench for alu_issue_ctrl with a
// behavioural ALU in the loop, plus hand-written reset and backpressure
// sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic [31:0] ALUResult;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_taken;
  logic        rsp_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_a(req_a), .req_b(req_b),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ALUResult(ALUResult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the DUT
  always_comb begin
    case (Operation)
      4'b0000: ALUResult = SrcA & SrcB;
      4'b0010: ALUResult = SrcA + SrcB;
      4'b0100: ALUResult = SrcA ^ SrcB;
      4'b1000: ALUResult = {31'd0, SrcA == SrcB};
      4'b1101: ALUResult = {31'd0, $signed(SrcA) < $signed(SrcB)};
      default: ALUResult = 32'd0;
    endcase
  end

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
    logic        illegal;
    logic [3:0]  op;      // Operation seen on the first ALU pass
    int          lat;     // cycles from accept edge to rsp_valid
    int          passes;  // cycles with Operation != 1111
    int          hold;    // cycles of rsp_ready=0 after rsp_valid
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          passes;
    int          lat;
    logic [3:0]  first_op;
    v = vecs[idx];
    @(negedge clk);
    req_aluop  = v.aluop;
    req_funct3 = v.f3;
    req_funct7 = v.f7;
    req_a      = v.a;
    req_b      = v.b;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    check($sformatf("v%0d_req_ready_idle", idx), req_ready, 1);
    @(negedge clk);
    // A second request held on the channel while busy must be ignored
    req_aluop  = 2'b10;
    req_funct3 = 3'b111;
    req_funct7 = 7'h7F;
    req_a      = 32'hDEADBEEF;
    req_b      = 32'hCAFEF00D;
    passes   = 0;
    lat      = 0;
    first_op = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      if (Operation !== 4'hF) begin
        if (passes == 0) first_op = Operation;
        passes++;
      end
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_result", idx), rsp_result, v.res);
    check($sformatf("v%0d_taken", idx), rsp_taken, v.taken);
    check($sformatf("v%0d_illegal", idx), rsp_illegal, v.illegal);
    check($sformatf("v%0d_operation", idx), first_op, v.op);
    check($sformatf("v%0d_passes", idx), passes, v.passes);
    check($sformatf("v%0d_req_ready_busy", idx), req_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("v%0d_hold%0d_valid", idx, h), rsp_valid, 1);
      check($sformatf("v%0d_hold%0d_result", idx, h), rsp_result, v.res);
      check($sformatf("v%0d_hold%0d_req_ready", idx, h), req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_valid_after_hs", idx), rsp_valid, 0);
    check($sformatf("v%0d_req_ready_after_hs", idx), req_ready, 1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          aluop  f3      f7          a             b             res           tk    ill   op      lat p  hold
    vecs[0]  = '{2'b10, 3'b000, 7'b0000000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 4'b0010, 2, 1, 0};
    vecs[1]  = '{2'b01, 3'b001, 7'b0000000, 32'h1234,     32'h1234,     32'd1,        1'b0, 1'b0, 4'b1000, 2, 1, 0};
    vecs[2]  = '{2'b01, 3'b001, 7'b0000000, 32'h1234,     32'h1235,     32'd0,        1'b1, 1'b0, 4'b1000, 2, 1, 0};
    vecs[3]  = '{2'b01, 3'b000, 7'b0000000, 32'h77,       32'h77,       32'd1,        1'b1, 1'b0, 4'b1000, 2, 1, 0};
    vecs[4]  = '{2'b01, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0, 4'b1101, 2, 1, 0};
    vecs[5]  = '{2'b01, 3'b101, 7'b0000000, 32'd5,        32'd3,        32'd0,        1'b1, 1'b0, 4'b1101, 2, 1, 0};
    vecs[6]  = '{2'b01, 3'b101, 7'b0000000, 32'd2,        32'd9,        32'd1,        1'b0, 1'b0, 4'b1101, 2, 1, 0};
    vecs[7]  = '{2'b11, 3'b001, 7'b0000000, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1, 4'b1111, 1, 0, 0};
    vecs[8]  = '{2'b01, 3'b010, 7'b0000000, 32'd4,        32'd4,        32'd0,        1'b0, 1'b1, 4'b1111, 1, 0, 0};
    vecs[9]  = '{2'b10, 3'b111, 7'b0000000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0, 4'b0000, 2, 1, 4};
    vecs[10] = '{2'b10, 3'b100, 7'b0000000, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0, 4'b0100, 2, 1, 0};
    vecs[11] = '{2'b10, 3'b010, 7'b0000000, 32'd2,        32'hFFFFFFFE, 32'd0,        1'b0, 1'b0, 4'b1101, 2, 1, 0};
    vecs[12] = '{2'b11, 3'b000, 7'b1111111, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0, 4'b0010, 2, 1, 0};
    vecs[13] = '{2'b11, 3'b010, 7'b0000000, 32'hFFFFFFFD, 32'd4,        32'd1,        1'b0, 1'b0, 4'b1101, 2, 1, 0};
    vecs[14] = '{2'b10, 3'b000, 7'b0000001, 32'd6,        32'd1,        32'd0,        1'b0, 1'b1, 4'b1111, 1, 0, 0};
    vecs[15] = '{2'b10, 3'b111, 7'b0100000, 32'd6,        32'd1,        32'd0,        1'b0, 1'b1, 4'b1111, 1, 0, 0};
    vecs[16] = '{2'b00, 3'b010, 7'b0000000, 32'h1000,     32'h20,       32'h1020,     1'b0, 1'b0, 4'b0010, 2, 1, 0};
`ifdef ALU_ISSUE_SUB_EN
    vecs[17] = '{2'b10, 3'b000, 7'b0100000, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 4'b0010, 3, 2, 2};
`else
    vecs[17] = '{2'b10, 3'b000, 7'b0100000, 32'd3,        32'd5,        32'd0,        1'b0, 1'b1, 4'b1111, 1, 0, 0};
`endif
    vecs[18] = '{2'b11, 3'b100, 7'b0000000, 32'hAAAA,     32'h5555,     32'hFFFF,     1'b0, 1'b0, 4'b0100, 2, 1, 1};

    reset      = 1'b0;
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    req_aluop  = 2'b00;
    req_funct3 = 3'b000;
    req_funct7 = 7'b0000000;
    req_a      = 32'd0;
    req_b      = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_taken", rsp_taken, 0);
    check("rst_rsp_illegal", rsp_illegal, 0);
    check("rst_operation", Operation, 4'hF);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset while in EXEC abandons the operation with no response
    @(negedge clk);
    req_aluop  = 2'b10;
    req_funct3 = 3'b000;
    req_funct7 = 7'b0000000;
    req_a      = 32'd100;
    req_b      = 32'd23;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_exec_operation", Operation, 4'b0010);
    check("midrst_exec_srca", SrcA, 32'd100);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_operation", Operation, 4'hF);
    check("midrst_rsp_result", rsp_result, 0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rsp%0d", c), rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Normal operation resumes after the abandoned transaction
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
